// File: rtl/led_pwm_capture_if.sv
// led_pwm_capture_if -- signal bundle between the LED PWM capture block and
// its user.
//   en       : measurement enable (user -> capture)
//   pwm_in   : raw LED drive lines, bit0=R bit1=G bit2=B (user -> capture)
//   duty_*   : lit-cycle count of the last completed window (capture -> user)
//   valid    : one-cycle pulse when duty_* update (capture -> user)
//   win_cnt  : completed-window count, wraps at 256 (capture -> user)
interface led_pwm_capture_if #(
  parameter int WIN_BITS = 8
);
  logic                en;
  logic [2:0]          pwm_in;
  logic [WIN_BITS:0]   duty_r;
  logic [WIN_BITS:0]   duty_g;
  logic [WIN_BITS:0]   duty_b;
  logic                valid;
  logic [7:0]          win_cnt;

  modport master (
    output en, pwm_in,
    input  duty_r, duty_g, duty_b, valid, win_cnt
  );

  modport slave (
    input  en, pwm_in,
    output duty_r, duty_g, duty_b, valid, win_cnt
  );
endinterface

// File: rtl/led_pwm_capture.sv
// led_pwm_capture -- measures how many cycles each of three LED drive lines
// is lit within back-to-back windows of 2^WIN_BITS clock cycles.
//   clk   : 24 MHz system clock, rising edge
//   rst_n : async active-low reset; release is expected to be synchronous
//           to clk (done upstream)
//   bus   : led_pwm_capture_if.slave (en, pwm_in in; duty_*, valid,
//           win_cnt out)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for en; results held, counters cleared
// FILL    | two cycles to flush stale values out of the synchronizer
// MEASURE | counting lit samples; windows run back to back
module led_pwm_capture #(
  parameter int WIN_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  led_pwm_capture_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILL    = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  localparam logic [2:0]          UNLIT   = {3{ACTIVE_LOW}};
  localparam logic [WIN_BITS-1:0] ONE     = {{(WIN_BITS-1){1'b0}}, 1'b1};
  localparam logic [WIN_BITS:0]   CNT_ZERO = '0;

  logic [2:0]          sync_q1;
  logic [2:0]          sync_q2;
  logic [2:0]          lit;
  logic [1:0]          state;
  logic                fill_cnt;
  logic [WIN_BITS-1:0] sample_cnt;
  logic                win_full;
  logic [WIN_BITS:0]   lit_cnt [3];
  logic [WIN_BITS:0]   duty_q  [3];
  logic                valid_q;
  logic [7:0]          win_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= UNLIT;
      sync_q2 <= UNLIT;
    end else begin
      sync_q1 <= bus.pwm_in;
      sync_q2 <= sync_q1;
    end
  end

  assign lit = sync_q2 ^ UNLIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fill_cnt   <= 1'b0;
      sample_cnt <= '0;
      win_full   <= 1'b0;
      valid_q    <= 1'b0;
      win_q      <= 8'd0;
      for (int c = 0; c < 3; c++) begin
        lit_cnt[c] <= CNT_ZERO;
        duty_q[c]  <= CNT_ZERO;
      end
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            state    <= FILL;
            fill_cnt <= 1'b1;
          end
        end
        FILL: begin
          if (!bus.en) begin
            state    <= IDLE;
            fill_cnt <= 1'b0;
          end else if (fill_cnt == 1'b0) begin
            state      <= MEASURE;
            sample_cnt <= '1;
            win_full   <= 1'b0;
          end else begin
            fill_cnt <= 1'b0;
          end
        end
        MEASURE: begin
          if (!bus.en) begin
            // abandon the partial window; results stay as they were
            state      <= IDLE;
            sample_cnt <= '0;
            win_full   <= 1'b0;
            for (int c = 0; c < 3; c++) lit_cnt[c] <= CNT_ZERO;
          end else begin
            // down-counter wraps from 0 back to all-ones, so the window
            // length repeats without reloading
            sample_cnt <= sample_cnt - ONE;
            win_full   <= (sample_cnt == '0);
            if (win_full) begin
              // publish the finished window and take the first sample of
              // the next one on the same edge, so there is no gap
              valid_q <= 1'b1;
              win_q   <= win_q + 8'd1;
              for (int c = 0; c < 3; c++) begin
                duty_q[c]  <= lit_cnt[c];
                lit_cnt[c] <= {{WIN_BITS{1'b0}}, lit[c]};
              end
            end else begin
              for (int c = 0; c < 3; c++)
                lit_cnt[c] <= lit_cnt[c] + {{WIN_BITS{1'b0}}, lit[c]};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.duty_r  = duty_q[0];
  assign bus.duty_g  = duty_q[1];
  assign bus.duty_b  = duty_q[2];
  assign bus.valid   = valid_q;
  assign bus.win_cnt = win_q;

endmodule

// File: tb/tb_led_pwm_capture.sv
module tb_led_pwm_capture;

  localparam int WB  = 8;
  localparam int WIN = 1 << WB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  led_pwm_capture_if #(.WIN_BITS(WB)) bus ();

  led_pwm_capture #(.WIN_BITS(WB), .ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #21 clk = ~clk;

  // Per-channel periodic pattern: lit when ((tick + phase) mod period) < d.
  // Period is a power of two dividing the window, so every window holds the
  // same number of lit samples: d * (WIN / period).
  int          cfg_p  [3] = '{1, 1, 1};
  int          cfg_d  [3] = '{0, 0, 0};
  int          cfg_ph [3] = '{0, 0, 0};
  int unsigned tick = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_win = 0;
  int exp_duty [3];

  function automatic logic [2:0] pattern(input int unsigned t);
    logic [2:0] v;
    for (int c = 0; c < 3; c++)
      v[c] = (((t + cfg_ph[c]) % cfg_p[c]) < cfg_d[c]) ? 1'b0 : 1'b1;
    return v;
  endfunction

  initial begin
    bus.en     = 1'b1;
    bus.pwm_in = pattern(0);
    forever begin
      @(negedge clk);
      tick++;
      bus.pwm_in = pattern(tick);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n = index of the edge (0 = first edge stepped) after which valid is seen
  task automatic wait_valid(output int n);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (bus.valid === 1'b1) begin
        seen = 1'b1;
        n = i;
        break;
      end
    end
    chk("valid_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic set_cfg(input int c, input int p, input int d, input int ph);
    cfg_p[c]    = p;
    cfg_d[c]    = d;
    cfg_ph[c]   = ph;
    exp_duty[c] = d * (WIN / p);
  endtask

  task automatic chk_duty();
    chk("duty_r", bus.duty_r, exp_duty[0]);
    chk("duty_g", bus.duty_g, exp_duty[1]);
    chk("duty_b", bus.duty_b, exp_duty[2]);
  endtask

  task automatic next_window(input bit check_duty);
    int n;
    wait_valid(n);
    exp_win = (exp_win + 1) % 256;
    chk("period", n, WIN - 1);
    chk("win_cnt", bus.win_cnt, exp_win);
    if (check_duty) chk_duty();
  endtask

  initial begin
    int n;
    int k;

    // reset state, en high throughout, all LEDs dark
    for (int c = 0; c < 3; c++) set_cfg(c, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty_r", bus.duty_r, 0);
    chk("rst_duty_g", bus.duty_g, 0);
    chk("rst_duty_b", bus.duty_b, 0);
    chk("rst_valid", {31'd0, bus.valid}, 0);
    chk("rst_win", bus.win_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    exp_win = 1;
    chk("first_latency", n, WIN + 3);
    chk_duty();
    chk("first_win", bus.win_cnt, exp_win);

    // all LEDs fully lit
    for (int c = 0; c < 3; c++) set_cfg(c, 1, 1, 0);
    next_window(1'b0);
    next_window(1'b1);
    next_window(1'b1);

    // R lit 64/256, G 128/256, B never, arbitrary phases
    set_cfg(0, WIN, 64,  $urandom_range(0, WIN - 1));
    set_cfg(1, WIN, 128, $urandom_range(0, WIN - 1));
    set_cfg(2, WIN, 0,   $urandom_range(0, WIN - 1));
    next_window(1'b0);
    next_window(1'b1);
    next_window(1'b1);

    // random periodic patterns
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        k = $urandom_range(0, WB);
        set_cfg(c, 1 << k, $urandom_range(0, 1 << k), $urandom_range(0, WIN - 1));
      end
      next_window(1'b0);
      next_window(1'b1);
      next_window(1'b1);
    end

    // en dropped at sample 100, re-raised 10 cycles later
    repeat (99) step();
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("gap_valid", {31'd0, bus.valid}, 0);
      chk("gap_win", bus.win_cnt, exp_win);
      chk("gap_duty_r", bus.duty_r, exp_duty[0]);
    end
    bus.en = 1'b1;
    wait_valid(n);
    exp_win = (exp_win + 1) % 256;
    chk("restart_latency", n, WIN + 3);
    chk("restart_win", bus.win_cnt, exp_win);
    chk_duty();

    // run until the window counter wraps
    for (int c = 0; c < 3; c++) set_cfg(c, 1, 1, 0);
    next_window(1'b0);
    while (exp_win != 255) next_window(1'b1);
    chk("win_255", bus.win_cnt, 255);
    next_window(1'b1);
    chk("win_wrap0", bus.win_cnt, 0);
    next_window(1'b1);
    chk("win_wrap1", bus.win_cnt, 1);

    // short reset pulse between edges, mid-window
    repeat (50) step();
    #5 rst_n = 1'b0;
    #1;
    chk("pulse_duty_r", bus.duty_r, 0);
    chk("pulse_duty_g", bus.duty_g, 0);
    chk("pulse_duty_b", bus.duty_b, 0);
    chk("pulse_valid", {31'd0, bus.valid}, 0);
    chk("pulse_win", bus.win_cnt, 0);
    #2 rst_n = 1'b1;
    exp_win = 0;
    wait_valid(n);
    exp_win = 1;
    chk("post_rst_latency", n, WIN + 3);
    chk("post_rst_win", bus.win_cnt, exp_win);
    chk_duty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
